// File: rtl/microcode_sequencer.sv
// Micro-PC sequencer for the multicycle RISC-V core: next-address decode plus microword split.
// Optional MICROSEQ_PERF_EN adds cycle_count / instret_count performance counters.
module microcode_sequencer #(
  parameter int unsigned      UPC_W     = 4,
  parameter logic [UPC_W-1:0] HALT_ADDR = 4'd15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic [15:0]      uword,
  output logic [UPC_W-1:0] uaddr,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic             halted
`ifdef MICROSEQ_PERF_EN
  ,
  output logic [31:0]      cycle_count,
  output logic [31:0]      instret_count
`endif
);

  typedef enum logic [UPC_W-1:0] {
    U_FETCH     = UPC_W'(0),
    U_DECODE    = UPC_W'(1),
    U_MEM_ADR   = UPC_W'(2),
    U_MEM_READ  = UPC_W'(3),
    U_MEM_WB    = UPC_W'(4),
    U_MEM_WRITE = UPC_W'(5),
    U_EXEC_R    = UPC_W'(6),
    U_ALU_WB    = UPC_W'(7),
    U_EXEC_I    = UPC_W'(8),
    U_JAL       = UPC_W'(9),
    U_BEQ       = UPC_W'(10),
    U_HALT      = HALT_ADDR
  } upc_t;

  typedef enum logic [2:0] {
    AC_SEQ    = 3'd0,
    AC_DISP1  = 3'd1,
    AC_DISP2  = 3'd2,
    AC_FETCH  = 3'd3,
    AC_ALU_WB = 3'd4
  } addr_ctl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  upc_t      upc;
  upc_t      upc_next;
  addr_ctl_t addr_ctl;
  logic      active;
  logic      stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) upc <= U_FETCH;
    else       upc <= upc_next;
  end

  assign uaddr = upc;

  always_comb begin
    upc_next   = upc;
    addr_ctl   = addr_ctl_t'(uword[2:0]);
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    result_src = '0;
    alu_src_a  = '0;
    alu_src_b  = '0;
    alu_op     = '0;
    illegal_op = 1'b0;
    active     = (upc <= U_BEQ);
    stall      = ((upc == U_FETCH) || (upc == U_MEM_READ) || (upc == U_MEM_WRITE)) && !mem_ready;

    // Unused addresses (and halt itself) ignore the microword and fall into halt.
    if (!active) begin
      upc_next = U_HALT;
    end else begin
      adr_src    = uword[11];
      result_src = uword[10:9];
      alu_src_a  = uword[8:7];
      alu_src_b  = uword[6:5];
      alu_op     = uword[4:3];
      pc_write   = ((upc == U_BEQ) ? zero : uword[15]) && !stall;
      reg_write  = uword[14] && !stall;
      mem_write  = uword[13];
      ir_write   = uword[12] && !stall;
      if (!stall) begin
        case (addr_ctl)
          AC_SEQ:    upc_next = upc_t'(upc + UPC_W'(1));
          AC_DISP1: begin
            case (opcode)
              OP_LOAD, OP_STORE: upc_next = U_MEM_ADR;
              OP_R:              upc_next = U_EXEC_R;
              OP_I:              upc_next = U_EXEC_I;
              OP_JAL:            upc_next = U_JAL;
              OP_BRANCH:         upc_next = U_BEQ;
              default: begin
                upc_next   = U_HALT;
                illegal_op = 1'b1;
              end
            endcase
          end
          AC_DISP2: begin
            case (opcode)
              OP_LOAD:  upc_next = U_MEM_READ;
              OP_STORE: upc_next = U_MEM_WRITE;
              default: begin
                upc_next   = U_HALT;
                illegal_op = 1'b1;
              end
            endcase
          end
          AC_FETCH:  upc_next = U_FETCH;
          AC_ALU_WB: upc_next = U_ALU_WB;
          default: begin
            upc_next   = U_HALT;
            illegal_op = 1'b1;
          end
        endcase
      end
    end

    if (reset) begin
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign halted = (upc == U_HALT) && !reset;

`ifdef MICROSEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (upc != U_HALT) cycle_count <= cycle_count + 32'd1;
      if ((upc != U_FETCH) && (upc_next == U_FETCH)) instret_count <= instret_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomized self-checking bench for microcode_sequencer against a rule-level reference model.
// Build with MICROSEQ_PERF_EN defined to also check the performance counters.
module tb_microcode_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [15:0] uword;
  logic [3:0]  uaddr;
  logic        pc_write, reg_write, mem_write, ir_write, adr_src;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic        illegal_op, halted;
`ifdef MICROSEQ_PERF_EN
  logic [31:0] cycle_count, instret_count;
`endif

  logic [15:0] rom [16];
  int          disp1 [int];
  int          disp2 [int];
  int          total = 0;
  int          bad = 0;
  int          exp_upc = 0;
  int unsigned exp_cyc = 0;
  int unsigned exp_ret = 0;
  logic [6:0]  legal [6];

  always #5 clk = ~clk;
  assign uword = rom[uaddr];

  microcode_sequencer #(.UPC_W(4), .HALT_ADDR(4'd15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .uword(uword), .uaddr(uaddr), .pc_write(pc_write), .reg_write(reg_write),
    .mem_write(mem_write), .ir_write(ir_write), .adr_src(adr_src),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .halted(halted)
`ifdef MICROSEQ_PERF_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: outputs and next micro-address straight from the sequencing rules.
  function automatic void model(input int upc, input logic [15:0] uw, input logic [6:0] op,
                                input logic z, input logic rdy, output logic [3:0] en,
                                output logic [8:0] sel, output logic ill, output int nxt);
    logic stall;
    en = '0; sel = '0; ill = 1'b0; nxt = 15;
    if (upc > 10) return;
    stall = (upc == 0 || upc == 3 || upc == 5) && !rdy;
    sel = uw[11:3];
    en = {((upc == 10) ? z : uw[15]) & ~stall, uw[14] & ~stall, uw[13], uw[12] & ~stall};
    if (stall) nxt = upc;
    else case (uw[2:0])
      3'd0: nxt = upc + 1;
      3'd1: if (disp1.exists(int'(op))) nxt = disp1[int'(op)]; else ill = 1'b1;
      3'd2: if (disp2.exists(int'(op))) nxt = disp2[int'(op)]; else ill = 1'b1;
      3'd3: nxt = 0;
      3'd4: nxt = 7;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic drive(input logic [6:0] op, input logic z, input logic rdy);
    opcode = op; zero = z; mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    logic [3:0] en;
    logic [8:0] sel;
    logic       ill;
    int         nxt;
    @(negedge clk);
    model(exp_upc, rom[exp_upc], opcode, zero, mem_ready, en, sel, ill, nxt);
    check("uaddr", 32'(uaddr), exp_upc);
    check("enables", 32'({pc_write, reg_write, mem_write, ir_write}), 32'(en));
    check("selects", 32'({adr_src, result_src, alu_src_a, alu_src_b, alu_op}), 32'(sel));
    check("illegal_op", 32'(illegal_op), 32'(ill));
    check("halted", 32'(halted), 32'(exp_upc == 15));
`ifdef MICROSEQ_PERF_EN
    check("cycle_count", cycle_count, exp_cyc);
    check("instret_count", instret_count, exp_ret);
`endif
    @(posedge clk);
    if (exp_upc != 15) exp_cyc++;
    if (exp_upc != 0 && nxt == 0) exp_ret++;
    exp_upc = nxt;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_uaddr", 32'(uaddr), 0);
    check("rst_ctl", 32'({pc_write, reg_write, mem_write, ir_write, illegal_op, halted}), 0);
    @(posedge clk);
    #1;
    check("rst_hold", 32'(uaddr), 0);
    reset = 1'b0;
    exp_upc = 0; exp_cyc = 0; exp_ret = 0;
  endtask

  task automatic load_microcode();
    rom[0]  = {5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0};
    rom[1]  = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'd1};
    rom[2]  = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'd2};
    rom[3]  = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0};
    rom[4]  = {5'b01000, 2'b01, 2'b00, 2'b00, 2'b00, 3'd3};
    rom[5]  = {5'b00101, 2'b00, 2'b00, 2'b00, 2'b00, 3'd3};
    rom[6]  = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'd4};
    rom[7]  = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'd3};
    rom[8]  = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b10, 3'd4};
    rom[9]  = {5'b10000, 2'b00, 2'b01, 2'b10, 2'b00, 3'd4};
    rom[10] = {5'b10000, 2'b00, 2'b10, 2'b00, 2'b01, 3'd3};
    for (int i = 11; i < 16; i++) rom[i] = 16'hFFFF;
  endtask

  // Runs one instruction from Fetch with memory always ready, recording uaddr/pc_write/reg_write.
  task automatic walk(input logic [6:0] op, input logic z, output logic [31:0] ups,
                      output logic [7:0] pw, output logic [7:0] rw);
    ups = '0; pw = '0; rw = '0;
    drive(op, z, 1'b1);
    for (int n = 0; n < 8; n++) begin
      ups = {ups[27:0], uaddr};
      pw  = {pw[6:0], pc_write};
      rw  = {rw[6:0], reg_write};
      if (n > 0 && uaddr == 4'd0) break;
      tick();
    end
  endtask

  initial begin
    logic [31:0] ups;
    logic [7:0]  pw, rw;
    logic [6:0]  op;
    int unsigned ret0;

    disp1['h03] = 2; disp1['h23] = 2; disp1['h33] = 6;
    disp1['h13] = 8; disp1['h6F] = 9; disp1['h63] = 10;
    disp2['h03] = 3; disp2['h23] = 5;
    legal = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63};
    opcode = 7'h03; zero = 1'b0; mem_ready = 1'b1;
    load_microcode();
    do_reset();

    walk(7'h03, 1'b0, ups, pw, rw);
    check("lw_seq", ups, 32'h012340);
    check("lw_regw", 32'(rw), 32'b000010);
    check("lw_wb_sel", 32'(rom[4][10:9]), 32'b01);
    walk(7'h13, 1'b0, ups, pw, rw);
    check("addi_seq", ups, 32'h01870);
    check("addi_regw", 32'(rw), 32'b00010);
    walk(7'h6F, 1'b0, ups, pw, rw);
    check("jal_seq", ups, 32'h01970);
    check("jal_pcw", 32'(pw), 32'b10101);
    walk(7'h33, 1'b0, ups, pw, rw);
    check("r_seq", ups, 32'h01670);
    walk(7'h63, 1'b1, ups, pw, rw);
    check("beq_t_seq", ups, 32'h01A0);
    check("beq_t_pcw", 32'(pw), 32'b1011);
    walk(7'h63, 1'b0, ups, pw, rw);
    check("beq_nt_seq", ups, 32'h01A0);
    check("beq_nt_pcw", 32'(pw), 32'b1001);

    drive(7'h23, 1'b0, 1'b1);
    repeat (3) tick();
    drive(7'h23, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("sw_hold", 32'(uaddr), 5);
      check("sw_memw", 32'(mem_write), 1);
      tick();
    end
    drive(7'h23, 1'b0, 1'b1);
    check("sw_memw_rdy", 32'(mem_write), 1);
    tick();
    check("sw_done", 32'(uaddr), 0);

    ret0 = exp_ret;
    drive(7'h13, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("fetch_stall_en", 32'({ir_write, pc_write}), 0);
      check("fetch_stall_upc", 32'(uaddr), 0);
      tick();
    end
    drive(7'h13, 1'b0, 1'b1);
    check("fetch_ready_en", 32'({ir_write, pc_write}), 32'b11);
    tick();
    check("fetch_adv", 32'(uaddr), 1);
    for (int n = 0; n < 8 && uaddr != 4'd0; n++) tick();
    check("instret_step", exp_ret - ret0, 1);

    drive(7'h7F, 1'b0, 1'b1);
    tick();
    check("ill_pulse", 32'(illegal_op), 1);
    tick();
    check("ill_once", 32'(illegal_op), 0);
    for (int i = 0; i < 20; i++) begin
      check("halt_hold", 32'({uaddr, halted, pc_write, reg_write, mem_write, ir_write}), 32'h1F0);
      tick();
    end
    do_reset();
    check("halt_clear", 32'({uaddr, halted}), 0);

    for (int k = 0; k < 300; k++) begin
      op = legal[$urandom_range(0, 5)];
      if ($urandom_range(0, 19) == 0) op = 7'($urandom);
      for (int n = 0; n < 40; n++) begin
        drive(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        tick();
        if (uaddr == 4'd0 || uaddr == 4'd15) break;
      end
      if (uaddr == 4'd15) begin
        repeat (2) tick();
        do_reset();
      end
    end

    for (int r = 0; r < 16; r++) rom[r] = 16'($urandom);
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      op = ($urandom_range(0, 1) == 0) ? legal[$urandom_range(0, 5)] : 7'($urandom);
      drive(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      tick();
      if ((uaddr == 4'd15 && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0) begin
        for (int r = 0; r < 16; r++) rom[r] = 16'($urandom);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
